// File: rtl/arb_out_fifo.sv
`default_nettype none
// ============================================================================
// arb_out_fifo : show-ahead output FIFO behind the round-robin arbiter; overflow
// is dropped and flagged. Optional ARB_OUT_FIFO_DROP_CNT_EN adds a drop counter.
// Rev 1.0
// ============================================================================
module arb_out_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_ready,
  output logic              o_full,
  output logic              o_empty,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_overflow,
  input  logic              i_clr_ovf,
  output logic [7:0]        o_drop_cnt
);

  localparam int               PTR_W      = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] C_FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic              ovf_q, ovf_d;
  logic              full, empty, push, pop, drop;

  assign full  = (count_q == C_FULL_CNT);
  assign empty = (count_q == '0);
  assign pop   = !empty && i_ready;
  assign push  = i_valid && (!full || pop);
  assign drop  = i_valid && !push;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    ovf_d    = ovf_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Head register preloads the next entry; the word being written this cycle
    // becomes the head when it lands exactly at the new read pointer.
    if (count_d != '0) begin
      if (push && (wr_ptr_q == rd_ptr_d)) head_d = i_data;
      else                                head_d = mem_q[rd_ptr_d];
    end

    if (drop)           ovf_d = 1'b1;
    else if (i_clr_ovf) ovf_d = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= i_data;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      ovf_q    <= ovf_d;
    end
  end

  assign o_valid    = !empty;
  assign o_data     = head_q;
  assign o_full     = full;
  assign o_empty    = empty;
  assign o_count    = count_q;
  assign o_overflow = ovf_q;

`ifdef ARB_OUT_FIFO_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      if (i_clr_ovf)                drop_cnt_d = 8'd1;
      else if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end else if (i_clr_ovf) begin
      drop_cnt_d = 8'd0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) drop_cnt_q <= 8'd0;
    else            drop_cnt_q <= drop_cnt_d;
  end

  assign o_drop_cnt = drop_cnt_q;
`else
  assign o_drop_cnt = 8'd0;
`endif

endmodule
`default_nettype wire
